// File: rtl/sched_step_ctrl_if.sv
// rtl/sched_step_ctrl_if.sv - handshake and configuration bundle for sched_step_ctrl
// Signals:
//   clk_en, flush, enable, start           : control from the host side
//   dimensionality, ranges, sched_strides,
//   sched_starting_addr                     : schedule configuration
//   step_ready                              : consumer accepts step this cycle
//   step, busy, done                        : controller outputs
// Modports: master = host/consumer side, slave = sched_step_ctrl.
interface sched_step_ctrl_if #(
    parameter int ITERATOR_SUPPORT = 6,
    parameter int CONFIG_WIDTH     = 16
);
    logic                                              clk_en;
    logic                                              flush;
    logic                                              enable;
    logic                                              start;
    logic [3:0]                                        dimensionality;
    logic [ITERATOR_SUPPORT-1:0][CONFIG_WIDTH-1:0]     ranges;
    logic [ITERATOR_SUPPORT-1:0][CONFIG_WIDTH-1:0]     sched_strides;
    logic [CONFIG_WIDTH-1:0]                           sched_starting_addr;
    logic                                              step_ready;
    logic                                              step;
    logic                                              busy;
    logic                                              done;

    modport master (
        output clk_en, flush, enable, start, dimensionality, ranges,
               sched_strides, sched_starting_addr, step_ready,
        input  step, busy, done
    );

    modport slave (
        input  clk_en, flush, enable, start, dimensionality, ranges,
               sched_strides, sched_starting_addr, step_ready,
        output step, busy, done
    );
endinterface

// File: rtl/sched_step_ctrl.sv
// rtl/sched_step_ctrl.sv - cycle-schedule step sequencer for an address generator
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : control, schedule configuration, step/step_ready handshake,
//                  busy/done status (see sched_step_ctrl_if)
//   stall_cycles : count of stalled step cycles, present only when
//                  SCHED_STEP_CTRL_STALL_CNT_EN is defined
module sched_step_ctrl #(
    parameter int ITERATOR_SUPPORT = 6,
    parameter int CONFIG_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sched_step_ctrl_if.slave        bus
`ifdef SCHED_STEP_CTRL_STALL_CNT_EN
    ,
    output logic [CONFIG_WIDTH-1:0] stall_cycles
`endif
);
    localparam int N = ITERATOR_SUPPORT;
    localparam int W = CONFIG_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [W-1:0] dim_counter [N];
    logic [W-1:0] current_loc [N];
    logic [W-1:0] cycle_count;
    logic [W-1:0] range_last  [N];
    logic [N-1:0] at_last;
    logic [N-1:0] update;
    logic [3:0]   dim_eff;
    logic [W-1:0] sched_addr;
    logic         final_hit;
    logic         step;
    logic         accept;
    logic         stall;
    logic         start_go;
    logic         do_flush;

    // Dimensionality beyond the hardware loop count is clamped.
    assign dim_eff = (bus.dimensionality > 4'(N)) ? 4'(N) : bus.dimensionality;

    always_comb begin
        sched_addr = bus.sched_starting_addr;
        update     = '0;
        at_last    = '0;
        final_hit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            // A zero range behaves as a single iteration.
            range_last[i] = (bus.ranges[i] == '0) ? '0 : bus.ranges[i] - 1'b1;
            at_last[i]    = (dim_counter[i] == range_last[i]);
            if (i < int'(dim_eff)) begin
                sched_addr = sched_addr + current_loc[i];
            end
        end
        // Carry chain: dim i moves only when every inner dim is at its last value.
        update[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            update[i] = update[i-1] & at_last[i-1];
        end
        for (int i = 0; i < N; i++) begin
            if (i == int'(dim_eff) - 1) begin
                final_hit = update[i] & at_last[i];
            end
        end
    end

    assign do_flush = bus.clk_en & bus.flush;
    assign start_go = bus.clk_en & bus.start & bus.enable & (state != ST_RUN);
    assign step     = bus.clk_en & (state == ST_RUN) & (cycle_count >= sched_addr);
    assign accept   = step & bus.step_ready;
    assign stall    = step & ~bus.step_ready;

    always_comb begin
        state_nxt = state;
        if (do_flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        state_nxt = (dim_eff == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && final_hit) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (bus.clk_en) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            for (int i = 0; i < N; i++) begin
                dim_counter[i] <= '0;
                current_loc[i] <= '0;
            end
        end else if (bus.clk_en) begin
            if (do_flush || start_go) begin
                // Zeroing here makes the first RUN cycle see cycle_count == 0.
                cycle_count <= '0;
                for (int i = 0; i < N; i++) begin
                    dim_counter[i] <= '0;
                    current_loc[i] <= '0;
                end
            end else if (state == ST_RUN) begin
                if (!stall && cycle_count != '1) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                if (accept) begin
                    for (int i = 0; i < N; i++) begin
                        if (i < int'(dim_eff) && update[i]) begin
                            if (at_last[i]) begin
                                dim_counter[i] <= '0;
                                current_loc[i] <= '0;
                            end else begin
                                dim_counter[i] <= dim_counter[i] + 1'b1;
                                current_loc[i] <= current_loc[i] + bus.sched_strides[i];
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef SCHED_STEP_CTRL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (bus.clk_en) begin
            if (do_flush || start_go) begin
                stall_cycles <= '0;
            end else if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

    assign bus.step = step;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
endmodule
